// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit.
package bru_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } bru_state_t;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Saturating increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == STAT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bru_queue.sv
// Circular in-flight branch queue; pointers carry one extra wrap bit so
// full and empty are distinguishable. Head entry is readable combinationally.
module bru_queue
  import bru_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full queue is legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves queued fetch predictions against execute outcomes and redirects fetch.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolution_unit
  import bru_pkg::*;
#(
  parameter int size  = 32,
  parameter int depth = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            buble,
  input  logic            br_push,
  input  logic            br_pred_taken,
  input  logic [size-1:0] br_alt_pc,
  input  logic            ex_resolve,
  input  logic            ex_taken,
  input  logic            ex_is_jalr,
  input  logic [size-1:0] ex_jalr_target,
  output logic [size-1:0] Correct_PC,
  output logic            isValid,
  output logic            flush,
  output logic            q_full,
  output logic            err_ovf,
  output logic            err_unf,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int ENTRY_W = size + 1;

  bru_state_t        state_q, state_d;
  logic [size-1:0]   cpc_q, cpc_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;

  logic              q_push, q_pop, q_clear, q_empty;
  logic [ENTRY_W-1:0] q_dout;
  logic              head_pred;
  logic [size-1:0]   head_alt;
  logic              in_run, accept, redirect;
  logic [size-1:0]   target;

  bru_queue #(.W(ENTRY_W), .DEPTH(depth)) u_queue (
    .clk   (clk),
    .rst   (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (q_clear),
    .din   ({br_pred_taken, br_alt_pc}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  assign head_pred = q_dout[size];
  assign head_alt  = q_dout[size-1:0];

  assign in_run   = (state_q == RUN);
  assign accept   = in_run && ex_resolve && !q_empty;
  assign redirect = accept && (ex_is_jalr || (ex_taken != head_pred));
  assign target   = ex_is_jalr ? ex_jalr_target : head_alt;

  always_comb begin
    state_d   = state_q;
    cpc_d     = cpc_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    q_push    = 1'b0;
    q_pop     = 1'b0;
    q_clear   = 1'b0;
    case (state_q)
      RUN: begin
        q_pop = accept;
        if (redirect) begin
          // Everything younger than the mispredicted branch is wrong-path.
          q_clear = 1'b1;
          cpc_d   = target;
          state_d = REDIRECT;
        end else begin
          q_push = br_push;
          if (br_push && q_full && !accept) err_ovf_d = 1'b1;
        end
        if (ex_resolve && q_empty) err_unf_d = 1'b1;
      end
      REDIRECT: begin
        if (!buble) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      cpc_q     <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpc_q     <= cpc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign Correct_PC = cpc_q;
  assign isValid    = (state_q == RUN);
  assign flush      = (state_q == REDIRECT);
  assign err_ovf    = err_ovf_q;
  assign err_unf    = err_unf_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (accept)   stat_br_q <= sat_inc(stat_br_q);
      if (redirect) stat_mp_q <= sat_inc(stat_mp_q);
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`else
  assign stat_branches = 32'd0;
  assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed and randomized checks of branch_resolution_unit against a queue-based model.
module tb_branch_resolution_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        buble = 1'b0;
  logic        br_push = 1'b0;
  logic        br_pred_taken = 1'b0;
  logic [31:0] br_alt_pc = '0;
  logic        ex_resolve = 1'b0;
  logic        ex_taken = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic [31:0] ex_jalr_target = '0;
  logic [31:0] Correct_PC;
  logic        isValid, flush, q_full, err_ovf, err_unf;
  logic [31:0] stat_branches, stat_mispred;

  branch_resolution_unit #(.size(32), .depth(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .buble          (buble),
    .br_push        (br_push),
    .br_pred_taken  (br_pred_taken),
    .br_alt_pc      (br_alt_pc),
    .ex_resolve     (ex_resolve),
    .ex_taken       (ex_taken),
    .ex_is_jalr     (ex_is_jalr),
    .ex_jalr_target (ex_jalr_target),
    .Correct_PC     (Correct_PC),
    .isValid        (isValid),
    .flush          (flush),
    .q_full         (q_full),
    .err_ovf        (err_ovf),
    .err_unf        (err_unf),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pred;
    logic [31:0] alt;
  } ent_t;

  ent_t        mq[$];
  bit          m_redir;
  logic [31:0] m_cpc;
  bit          m_ovf, m_unf;
  logic [31:0] m_nb, m_nm;
  int          total = 0;
  int          bad = 0;
  int          step_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_redir = 0;
    m_cpc   = '0;
    m_ovf   = 0;
    m_unf   = 0;
    m_nb    = '0;
    m_nm    = '0;
  endtask

  task automatic check_all();
    chk("Correct_PC", Correct_PC, m_cpc);
    chk("isValid", {31'd0, isValid}, {31'd0, !m_redir});
    chk("flush", {31'd0, flush}, {31'd0, m_redir});
    chk("q_full", {31'd0, q_full}, {31'd0, mq.size() == DEPTH});
    chk("err_ovf", {31'd0, err_ovf}, {31'd0, m_ovf});
    chk("err_unf", {31'd0, err_unf}, {31'd0, m_unf});
`ifdef BRU_STATS_EN
    chk("stat_branches", stat_branches, m_nb);
    chk("stat_mispred", stat_mispred, m_nm);
`else
    chk("stat_branches", stat_branches, 32'd0);
    chk("stat_mispred", stat_mispred, 32'd0);
`endif
  endtask

  // One clock of stimulus; the model advances by the rules for that edge.
  task automatic step(input bit push, input bit pred, input logic [31:0] alt,
                      input bit res, input bit taken, input bit jalr,
                      input logic [31:0] tgt, input bit bub);
    int          sz;
    bit          ok, rd;
    logic [31:0] t;
    ent_t        h, e;
    br_push = push; br_pred_taken = pred; br_alt_pc = alt;
    ex_resolve = res; ex_taken = taken; ex_is_jalr = jalr;
    ex_jalr_target = tgt; buble = bub;
    if (!m_redir) begin
      sz = mq.size();
      ok = res && (sz > 0);
      rd = 0;
      t  = '0;
      if (res && sz == 0) m_unf = 1;
      if (ok) begin
        h = mq.pop_front();
        m_nb = sat(m_nb);
        if (jalr) begin rd = 1; t = tgt; end
        else if (taken != h.pred) begin rd = 1; t = h.alt; end
      end
      if (rd) begin
        mq.delete();
        m_cpc = t;
        m_redir = 1;
        m_nm = sat(m_nm);
      end else if (push) begin
        if (sz < DEPTH || ok) begin
          e.pred = pred; e.alt = alt;
          mq.push_back(e);
        end else m_ovf = 1;
      end
    end else if (!bub) m_redir = 0;
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d push=%0b res=%0b taken=%0b jalr=%0b bub=%0b -> pc=%h valid=%0b qlen=%0d",
             step_no, push, res, taken, jalr, bub, Correct_PC, isValid, mq.size());
    check_all();
  endtask

  task automatic idle(input bit bub);
    step(0, 0, '0, 0, 0, 0, '0, bub);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #6;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Correct prediction: no redirect.
    step(1, 1, 32'h40, 0, 0, 0, '0, 0);
    step(0, 0, '0, 1, 1, 0, '0, 0);
    // Direction mispredict redirects to alt path for one cycle.
    step(1, 0, 32'h88, 0, 0, 0, '0, 0);
    step(0, 0, '0, 1, 1, 0, '0, 0);
    idle(0);
    // JALR with same-edge push; the push must be discarded.
    step(1, 1, 32'h100, 0, 0, 0, '0, 0);
    step(1, 1, 32'h104, 0, 0, 0, '0, 0);
    step(1, 1, 32'h108, 0, 0, 0, '0, 0);
    step(1, 1, 32'h10c, 1, 1, 1, 32'h200, 0);
    idle(0);
    step(0, 0, '0, 1, 1, 0, '0, 0);

    // Redirect held by stall; activity ignored, errors stay clear.
    pulse_reset();
    step(1, 0, 32'h300, 0, 0, 0, '0, 0);
    step(0, 0, '0, 1, 1, 0, '0, 1);
    step(1, 1, 32'h310, 1, 0, 0, '0, 1);
    step(0, 0, '0, 1, 1, 1, 32'h999, 1);
    step(1, 0, 32'h320, 0, 0, 0, '0, 1);
    idle(0);

    // Fill, overflow, push+pop while full across pointer wrap.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h400 + i, 0, 0, 0, '0, 0);
    step(1, 0, 32'h4ff, 0, 0, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h500 + i, 1, 0, 0, '0, 0);
    step(0, 0, '0, 1, 0, 0, '0, 0);
    step(0, 0, '0, 1, 1, 0, '0, 0);
    idle(0);

    // Underflow, then reset while redirecting.
    pulse_reset();
    step(0, 0, '0, 1, 1, 0, '0, 0);
    step(1, 1, 32'h600, 0, 0, 0, '0, 0);
    step(0, 0, '0, 1, 0, 0, '0, 1);
    pulse_reset();
    idle(0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom,
           $urandom_range(9, 0) < 4, $urandom_range(1, 0) == 1,
           $urandom_range(9, 0) == 0, $urandom, $urandom_range(1, 0) == 1);
      if (i == 200) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
